servant_clk_rst_ctrl: RTL

Parametrised clock-enable and reset sequencer for Servant board top-levels. It runs in the PLL/MMCM output clock domain and consumes the PLL `locked` flag. It produces a lock-filtered, stretched system reset, plus N staggered clock-enable outputs that drive BUFGCE CE pins in the board clock-gen wrapper. Unlike the single-shot lock-to-reset path, it filters lock glitches, re-sequences on lock loss, gates any number of channels and counts lock-loss events.

---
 rtl/servant_clk_pkg.sv | 18 +
 rtl/servant_sync2.sv | 24 ++
 rtl/servant_clk_rst_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/servant_clk_pkg.sv
// Shared encodings and widths for the Servant clock/reset sequencer.
package servant_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_STAGGER   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int LOSS_CNT_W = 8;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/servant_sync2.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module servant_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/servant_clk_rst_ctrl.sv
// Lock-filtered reset stretcher and staggered clock-enable sequencer.
// Re-sequences from WAIT_LOCK on any lock loss and counts loss events.
module servant_clk_rst_ctrl
  import servant_clk_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int LOCK_FILTER = 8,
  parameter int RST_CYCLES  = 16,
  parameter int STAGGER     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_locked,
  input  logic [CHANNELS-1:0]   i_en,
  output logic [CHANNELS-1:0]   o_en,
  output logic                  o_rst,
  output logic                  o_ready,
  output logic [LOSS_CNT_W-1:0] o_lock_loss_cnt
);

  localparam int FILT_W = cnt_width(LOCK_FILTER);
  localparam int HOLD_W = cnt_width(RST_CYCLES);
  localparam int STAG_W = cnt_width((CHANNELS - 1) * STAGGER);

  logic                  locked_s;
  logic                  loss;
  state_e                state_q, state_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [STAG_W-1:0]     stag_q, stag_d;
  logic [CHANNELS-1:0]   elig_q, elig_d;
  logic [CHANNELS-1:0]   en_q;
  logic                  ready_q;
  logic                  rst_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  servant_sync2 u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_locked),
    .o_q   (locked_s)
  );

  assign loss = !locked_s && (state_q != ST_WAIT_LOCK);

  always_comb begin
    state_d = state_q;
    filt_d  = '0;
    hold_d  = '0;
    stag_d  = '0;
    elig_d  = elig_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        elig_d = '0;
        if (locked_s) begin
          if (int'(filt_q) == LOCK_FILTER - 1) state_d = ST_HOLD;
          else                                 filt_d  = filt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (int'(hold_q) == RST_CYCLES - 1) begin
          state_d   = ST_STAGGER;
          elig_d[0] = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_STAGGER: begin
        stag_d = stag_q + 1'b1;
        // Channel k turns eligible k*STAGGER edges after channel 0.
        for (int k = 1; k < CHANNELS; k++) begin
          if (int'(stag_q) + 1 == k * STAGGER) elig_d[k] = 1'b1;
        end
        if (&elig_d) begin
          state_d = ST_RUN;
          stag_d  = '0;
        end
      end
      ST_RUN: ;
      default: state_d = ST_WAIT_LOCK;
    endcase
    // Lock loss overrides any transition or eligibility taken this cycle.
    if (loss) begin
      state_d = ST_WAIT_LOCK;
      filt_d  = '0;
      hold_d  = '0;
      stag_d  = '0;
      elig_d  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_WAIT_LOCK;
      filt_q     <= '0;
      hold_q     <= '0;
      stag_q     <= '0;
      elig_q     <= '0;
      en_q       <= '0;
      ready_q    <= 1'b0;
      rst_q      <= 1'b1;
      loss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      elig_q  <= elig_d;
      en_q    <= loss ? '0 : (elig_q & i_en);
      ready_q <= loss ? 1'b0 : (&elig_q);
      rst_q   <= (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD);
      if (loss && (loss_cnt_q != '1)) loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign o_en            = en_q;
  assign o_ready         = ready_q;
  assign o_rst           = rst_q;
  assign o_lock_loss_cnt = loss_cnt_q;

endmodule
